// File: rtl/counter_pkg.sv
// Shared constants and reference step function for the up/down modulo counter family.
package counter_pkg;

    localparam int unsigned WRAP     = 1;
    localparam int unsigned SATURATE = 0;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Returns {limit_event, next_count} for one enabled step; operands are zero-extended to 32 bits.
    function automatic logic [32:0] next_count(input logic [31:0] count,
                                               input logic        up_down,
                                               input logic [31:0] max_value,
                                               input logic        mode);
        logic        ev;
        logic [31:0] nx;
        ev = up_down ? (count == max_value) : (count == 32'd0);
        if (!ev) begin
            nx = up_down ? count + 32'd1 : count - 32'd1;
        end else if (mode) begin
            nx = up_down ? 32'd0 : max_value;
        end else begin
            nx = count;
        end
        return {ev, nx};
    endfunction

endpackage

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, clear, wrap or saturate limits,
// terminal count, registered limit pulse and sticky overflow flag.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH     = 4,
    parameter logic [WIDTH-1:0]  MAX_VALUE = {WIDTH{1'b1}},
    parameter int unsigned       WRAP_MODE = WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             ovf_sticky
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] load_clamped;

    assign tc           = up_down ? (count_q == MAX_VALUE) : (count_q == '0);
    assign load_clamped = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q & ~ovf_clr;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (enable) begin
            if (tc) begin
                // A step at the limit is an event whether it wraps or is blocked.
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
                if (WRAP_MODE == WRAP) begin
                    count_d = up_down ? '0 : MAX_VALUE;
                end
            end else begin
                count_d = up_down ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed and table-driven checks over four counter configurations, plus a
// randomised run of the wide instance against the package step function.
module tb_updown_mod_counter;
    import counter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, up_down, clear, load, ovf_clr;
    logic [15:0] load_value;

    logic [3:0]  c0, c1, c2;
    logic [15:0] c3;
    logic        t0, t1, t2, t3;
    logic        w0, w1, w2, w3;
    logic        o0, o1, o2, o3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4)) u_legacy (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_value(load_value[3:0]), .ovf_clr(ovf_clr),
        .count(c0), .tc(t0), .wrap_pulse(w0), .ovf_sticky(o0));

    updown_mod_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .WRAP_MODE(WRAP)) u_mod10 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_value(load_value[3:0]), .ovf_clr(ovf_clr),
        .count(c1), .tc(t1), .wrap_pulse(w1), .ovf_sticky(o1));

    updown_mod_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .WRAP_MODE(SATURATE)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_value(load_value[3:0]), .ovf_clr(ovf_clr),
        .count(c2), .tc(t2), .wrap_pulse(w2), .ovf_sticky(o2));

    updown_mod_counter #(.WIDTH(16), .MAX_VALUE(16'd1000), .WRAP_MODE(WRAP)) u_wide (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_value(load_value), .ovf_clr(ovf_clr),
        .count(c3), .tc(t3), .wrap_pulse(w3), .ovf_sticky(o3));

    typedef struct {
        logic       clr, ld, en, ud, oc;
        logic [3:0] lv;
        int         reps;
        logic [3:0] cnt;
        logic       tc, wp, ovf;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0; ovf_clr = 1'b0;
        load_value = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] m_cnt;
    logic        m_wp, m_ovf;
    logic [32:0] r;

    initial begin
        // clear, ld, en, ud, oc, lv, reps, cnt, tc, wp, ovf
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  1, 4'd0,  1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  1, 4'd5,  1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  5, 4'd5,  1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 1, 4'd15, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  1, 4'd0,  1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  1, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 1, 4'd15, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3,  1, 4'd3,  1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1, 4'd3,  1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  3, 4'd0,  1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1, 4'd15, 1'b0, 1'b1, 1'b1};

        // Legacy default counter.
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_count", 32'(c0), 32'd0);
        chk("rst_wrap", 32'(w0), 32'd0);
        chk("rst_ovf", 32'(o0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (5) step();
        chk("legacy_5", 32'(c0), 32'd5);
        repeat (10) step();
        chk("legacy_15", 32'(c0), 32'd15);
        chk("legacy_tc", 32'(t0), 32'd1);
        chk("legacy_no_wp_yet", 32'(w0), 32'd0);
        step();
        chk("legacy_wrap_cnt", 32'(c0), 32'd0);
        chk("legacy_wp", 32'(w0), 32'd1);
        chk("legacy_ovf", 32'(o0), 32'd1);
        enable = 1'b0;
        step();
        chk("legacy_wp_one_cycle", 32'(w0), 32'd0);
        chk("legacy_ovf_sticky", 32'(o0), 32'd1);

        // Async reset mid-cycle from count 7.
        load = 1'b1; load_value = 16'd7;
        step();
        load = 1'b0;
        chk("load7", 32'(c0), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_count", 32'(c0), 32'd0);
        chk("async_wrap", 32'(w0), 32'd0);
        chk("async_ovf", 32'(o0), 32'd0);
        enable = 1'b1;
        repeat (3) begin
            step();
            chk("rst_hold", 32'(c0), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b0;

        // Priority / suppression table on the legacy counter.
        for (int i = 0; i < 11; i++) begin
            clear = tbl[i].clr; load = tbl[i].ld; enable = tbl[i].en;
            up_down = tbl[i].ud; ovf_clr = tbl[i].oc; load_value = 16'(tbl[i].lv);
            repeat (tbl[i].reps) step();
            chk($sformatf("tbl%0d_count", i), 32'(c0), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_tc", i), 32'(t0), 32'(tbl[i].tc));
            chk($sformatf("tbl%0d_wp", i), 32'(w0), 32'(tbl[i].wp));
            chk($sformatf("tbl%0d_ovf", i), 32'(o0), 32'(tbl[i].ovf));
        end
        idle_inputs();
        up_down = 1'b0;
        #1;
        chk("tc_dir_down_at_15", 32'(t0), 32'd0);
        up_down = 1'b1;
        #1;
        chk("tc_comb_same_cycle", 32'(t0), 32'd1);

        // Modulo-10 down with wrap.
        do_reset();
        up_down = DIR_DOWN; load = 1'b1; load_value = 16'd2;
        step();
        chk("mod10_load", 32'(c1), 32'd2);
        load = 1'b0; enable = 1'b1;
        step();
        chk("mod10_1", 32'(c1), 32'd1);
        step();
        chk("mod10_0", 32'(c1), 32'd0);
        chk("mod10_tc0", 32'(t1), 32'd1);
        chk("mod10_no_wp", 32'(w1), 32'd0);
        step();
        chk("mod10_9", 32'(c1), 32'd9);
        chk("mod10_wp", 32'(w1), 32'd1);
        chk("mod10_tc9", 32'(t1), 32'd0);
        enable = 1'b0;
        step();
        chk("mod10_wp_drop", 32'(w1), 32'd0);
        chk("mod10_hold", 32'(c1), 32'd9);

        // Saturating modulo-10.
        do_reset();
        load = 1'b1; load_value = 16'd12;
        step();
        chk("sat_clamp", 32'(c2), 32'd9);
        chk("sat_tc", 32'(t2), 32'd1);
        load = 1'b0; enable = 1'b1;
        repeat (3) begin
            step();
            chk("sat_hold9", 32'(c2), 32'd9);
            chk("sat_wp", 32'(w2), 32'd1);
            chk("sat_ovf", 32'(o2), 32'd1);
        end
        ovf_clr = 1'b1;
        step();
        chk("sat_set_wins", 32'(o2), 32'd1);
        chk("sat_wp_cont", 32'(w2), 32'd1);
        enable = 1'b0;
        step();
        chk("sat_ovf_clr", 32'(o2), 32'd0);
        chk("sat_wp_off", 32'(w2), 32'd0);
        chk("sat_cnt_keep", 32'(c2), 32'd9);
        ovf_clr = 1'b0; clear = 1'b1;
        step();
        chk("sat_clear", 32'(c2), 32'd0);
        clear = 1'b0; enable = 1'b1; up_down = DIR_DOWN;
        step();
        chk("sat_floor", 32'(c2), 32'd0);
        chk("sat_floor_wp", 32'(w2), 32'd1);
        chk("sat_floor_ovf", 32'(o2), 32'd1);

        // Wide modulo-1001 counter.
        do_reset();
        load = 1'b1; load_value = 16'd999;
        step();
        chk("wide_load", 32'(c3), 32'd999);
        load = 1'b0; enable = 1'b1;
        step();
        chk("wide_1000", 32'(c3), 32'd1000);
        chk("wide_tc", 32'(t3), 32'd1);
        step();
        chk("wide_wrap", 32'(c3), 32'd0);
        chk("wide_wp", 32'(w3), 32'd1);
        m_cnt = 16'd0; m_wp = 1'b1; m_ovf = 1'b1;

        for (int n = 0; n < 10000; n++) begin
            clear      = ($urandom_range(31) == 0);
            load       = ($urandom_range(15) == 0);
            enable     = ($urandom_range(3) != 0);
            up_down    = 1'($urandom_range(1));
            ovf_clr    = ($urandom_range(15) == 0);
            load_value = 16'($urandom);
            #1;
            chk("rand_tc", 32'(t3), 32'(up_down ? (m_cnt == 16'd1000) : (m_cnt == 16'd0)));
            if (clear) begin
                m_cnt = 16'd0; m_wp = 1'b0; m_ovf = m_ovf & ~ovf_clr;
            end else if (load) begin
                m_cnt = (load_value > 16'd1000) ? 16'd1000 : load_value;
                m_wp = 1'b0; m_ovf = m_ovf & ~ovf_clr;
            end else if (enable) begin
                r = next_count(32'(m_cnt), up_down, 32'd1000, 1'b1);
                m_cnt = r[15:0];
                m_wp = r[32];
                m_ovf = r[32] | (m_ovf & ~ovf_clr);
            end else begin
                m_wp = 1'b0; m_ovf = m_ovf & ~ovf_clr;
            end
            step();
            chk("rand_count", 32'(c3), 32'(m_cnt));
            chk("rand_flags", {30'd0, w3, o3}, {30'd0, m_wp, m_ovf});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised successor to the team's 4-bit enable counter. It adds configurable width, a programmable modulus, up/down direction, synchronous load and clear, and a choice of wrap or saturate at the limits. It also provides a terminal-count output, a one-cycle wrap event and a sticky overflow flag. It sits in datapath control as a general-purpose event/timer counter. With default parameters and up_down=1 it behaves exactly like the legacy 4-bit wrap-around counter.

Parameters:
WIDTH, 4, counter width in bits (legal range 2..32)
MAX_VALUE, 2**WIDTH-1, highest count value; the modulus is MAX_VALUE+1 (requires 1 <= MAX_VALUE <= 2**WIDTH-1)
WRAP_MODE, 1, 1 = wrap at the limits; 0 = saturate at the limits

Ports:
clk  in  1  single clock, rising-edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  count step enable
up_down  in  1  1 = count up, 0 = count down
clear  in  1  synchronous clear to 0
load  in  1  synchronous load of load_value
load_value  in  WIDTH  value to load
ovf_clr  in  1  clears ovf_sticky
count  out  WIDTH  current count (registered)
tc  out  1  terminal count (combinational from count and up_down)
wrap_pulse  out  1  one-cycle registered wrap/limit event
ovf_sticky  out  1  sticky limit-event flag

Behaviour:
- Reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. While rst_n=0: count=0, wrap_pulse=0, ovf_sticky=0, immediately with no clock needed. Release is synchronous to clk.
- Per-rising-edge priority for count: clear > load > enable > hold.
  - clear=1: count <= 0; wrap_pulse <= 0.
  - load=1 (clear=0): count <= min(load_value, MAX_VALUE). Values above MAX_VALUE clamp to MAX_VALUE. wrap_pulse <= 0.
  - enable=1, up_down=1:
    - count < MAX_VALUE: count+1.
    - count == MAX_VALUE: count <= 0 if WRAP_MODE=1, else hold MAX_VALUE.
  - enable=1, up_down=0:
    - count > 0: count-1.
    - count == 0: count <= MAX_VALUE if WRAP_MODE=1, else hold 0.
  - enable=0: hold.
- Limit event: an enabled step taken while tc=1, i.e. a wrap in WRAP_MODE=1 or a blocked step in WRAP_MODE=0. clear or load in the same cycle suppresses the event.
- Latency: count updates on the edge after the inputs are sampled. There are no bubbles, so back-to-back enable steps once every cycle.
- tc = (up_down && count==MAX_VALUE) || (!up_down && count==0). tc is combinational, so it changes in the same cycle as up_down.
- wrap_pulse: registered. It is 1 for exactly the one cycle following the edge on which a limit event occurred, otherwise 0. In saturate mode with enable held at the limit it stays 1 on every cycle.
- ovf_sticky:
  - Set on the edge of a limit event.
  - Cleared on an edge with ovf_clr=1.
  - If set and clear coincide on the same edge, set wins (the new event is not lost).
  - clear and load do not affect it.
- Width rules: all arithmetic is WIDTH bits and unsigned, with no intermediate overflow. The MAX_VALUE comparison and clamp are done at WIDTH bits.
- Reset mid-count: assertion of rst_n overrides everything asynchronously. The first edge after release behaves per the priority rules.
- X-safety: outputs must never be X after reset.

Decomposition:
- Shared package counter_pkg holds:
  - localparams WRAP=1 and SATURATE=0;
  - the direction constants DIR_UP=1 and DIR_DOWN=0;
  - a pure function next_count(count, up_down, MAX, mode) returning {event, next}, reusable by the bench's reference model.
- No sub-module. This is single-level RTL.

Test Plan:
- Legacy default (WIDTH=4, MAX=15, WRAP): reset, then enable=1, up_down=1 for 5 edges → count=5. After 15 edges total → count=F, tc=1. One more edge → count=0, then wrap_pulse=1 for one cycle and ovf_sticky=1.
- Async reset: reach count=7, then drop rst_n mid-cycle between edges → count=0, wrap_pulse=0, ovf_sticky=0 before the next edge. Hold rst_n low with enable=1 → count stays 0.
- Modulo-10 down (MAX_VALUE=9, WRAP): load 2, then down 3 steps → 1, 0, 9. wrap_pulse=1 after the 0→9 edge. tc=1 while count=0 with up_down=0.
- Saturate (WRAP_MODE=0, MAX=9): load load_value=12 → count=9 (clamped). Up 3 more edges → count stays 9, wrap_pulse=1 each cycle, ovf_sticky=1. Pulse ovf_clr → ovf_sticky=0 only if no event on that edge.
- Priority: clear=1, load=1, load_value=5, enable=1 on one edge → count=0. Then load=1, enable=1, load_value=5 → count=5, not 6. Then enable=0 for 5 edges → count holds 5.
- Wide instance (WIDTH=16, MAX=1000, WRAP): load 999, up 2 → 1000, 0. Compare every cycle against counter_pkg::next_count over 10k random cycles of enable/up_down/load/clear with zero mismatches.
